// File: rtl/io_poll_master.sv
// ---------------------------------------------------------------------------
// io_poll_master
//
// Bus initiator for the memory-mapped switch/LED IO peripheral. It stands in
// for the CPU polling loop. Each round runs these steps:
//   1. Poll the status register until the switch data is ready.
//   2. Read the low and high switch bytes.
//   3. Combine the two bytes with the selected op.
//   4. Write the result to the LED register.
//   5. Poll the status register until the LED update is acknowledged.
//
// Parameters
//   POLL_GAP    idle cycles between consecutive status reads (0 = back-to-back)
//   TIMEOUT     max status reads in one poll phase; 0 disables the limit
//
// Ports
//   clk         clock, all state on the rising edge
//   reset       asynchronous, active-low reset
//   en          1 = run rounds continuously, 0 = stop at the next safe point
//   op          combine op, sampled in S_CALC: 00 add, 01 sub, 10 mul, 11 cat
//   pread       bus read strobe
//   pwrite      bus write strobe
//   addr        register address: 00 status, 01 LED, 10 switch lo, 11 switch hi
//   pwritedata  LED write data
//   preaddata   read data, valid in the same cycle as pread
//   busy        1 in any state other than S_IDLE
//   done        one-cycle pulse after a round's LED ack is seen
//   timeout     sticky poll-limit error; cleared on an en 0->1 transition
//   result      last value written to the LED register
//   rounds      completed-round counter, wraps at 16'hFFFF
// ---------------------------------------------------------------------------
module io_poll_master #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  op,
    output logic        pread,
    output logic        pwrite,
    output logic [1:0]  addr,
    output logic [11:0] pwritedata,
    input  logic [31:0] preaddata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [11:0] result,
    output logic [15:0] rounds
);

    // The poll counter holds the number of failed reads so far.
    // It only needs to reach TIMEOUT-1.
    localparam int PC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam int GC_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GC_W-1:0] GC_LAST = GC_W'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);

    localparam logic [1:0] A_STATUS = 2'b00;
    localparam logic [1:0] A_LED    = 2'b01;
    localparam logic [1:0] A_SWLO   = 2'b10;
    localparam logic [1:0] A_SWHI   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLLSW,
        S_GAPSW,
        S_RDLO,
        S_RDHI,
        S_CALC,
        S_WRLED,
        S_POLLLED,
        S_GAPLED
    } state_t;

    state_t state, state_nxt;

    logic [PC_W-1:0] poll_cnt;
    logic [GC_W-1:0] gap_cnt;
    logic [7:0]      lo;
    logic [7:0]      hi;
    logic            en_d;

    logic poll_limit;
    logic poll_clr;
    logic poll_inc;
    logic gap_clr;
    logic gap_inc;
    logic set_timeout;
    logic ld_lo;
    logic ld_hi;
    logic ld_result;
    logic round_done;

    // The switch bytes live in the low byte of the read data.
    // The status flags are bits 1 and 0.
    // The upper bits carry nothing this block uses.
    logic unused_rdata;
    assign unused_rdata = ^preaddata[31:8];

    // -----------------------------------------------------------------------
    // Combine helpers
    // -----------------------------------------------------------------------
    function automatic logic [11:0] sat12(input logic [15:0] p);
        return (p > 16'd4095) ? 12'hFFF : p[11:0];
    endfunction

    function automatic logic [11:0] sub12(input logic [7:0] a, input logic [7:0] b);
        logic signed [11:0] d;
        d = $signed({4'b0000, a}) - $signed({4'b0000, b});
        return d;
    endfunction

    function automatic logic [11:0] combine(input logic [1:0] f_op,
                                            input logic [7:0] f_hi,
                                            input logic [7:0] f_lo);
        logic [11:0] r;
        case (f_op)
            2'b00:   r = {3'b000, {1'b0, f_hi} + {1'b0, f_lo}};
            2'b01:   r = sub12(f_hi, f_lo);
            2'b10:   r = sat12({8'h00, f_hi} * {8'h00, f_lo});
            default: r = {f_hi[3:0], f_lo};
        endcase
        return r;
    endfunction

    assign poll_limit = (TIMEOUT != 0) && (poll_cnt == PC_LAST);

    // -----------------------------------------------------------------------
    // Bus and status decode: driven from the state register only
    // -----------------------------------------------------------------------
    always_comb begin
        pread      = 1'b0;
        pwrite     = 1'b0;
        addr       = A_STATUS;
        pwritedata = '0;
        case (state)
            S_POLLSW, S_POLLLED: begin
                pread = 1'b1;
                addr  = A_STATUS;
            end
            S_RDLO: begin
                pread = 1'b1;
                addr  = A_SWLO;
            end
            S_RDHI: begin
                pread = 1'b1;
                addr  = A_SWHI;
            end
            S_WRLED: begin
                pwrite     = 1'b1;
                addr       = A_LED;
                pwritedata = result;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    // -----------------------------------------------------------------------
    // Next-state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        poll_clr    = 1'b0;
        poll_inc    = 1'b0;
        gap_clr     = 1'b0;
        gap_inc     = 1'b0;
        set_timeout = 1'b0;
        ld_lo       = 1'b0;
        ld_hi       = 1'b0;
        ld_result   = 1'b0;
        round_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_POLLSW;
                    poll_clr  = 1'b1;
                end
            end
            S_POLLSW: begin
                // Dropping en aborts the switch poll, even if data is ready.
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (preaddata[1]) begin
                    state_nxt = S_RDLO;
                end else if (poll_limit) begin
                    state_nxt   = S_IDLE;
                    set_timeout = 1'b1;
                end else begin
                    poll_inc  = 1'b1;
                    gap_clr   = 1'b1;
                    state_nxt = (POLL_GAP == 0) ? S_POLLSW : S_GAPSW;
                end
            end
            S_GAPSW: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (gap_cnt == GC_LAST) begin
                    state_nxt = S_POLLSW;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            S_RDLO: begin
                ld_lo     = 1'b1;
                state_nxt = S_RDHI;
            end
            S_RDHI: begin
                ld_hi     = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: begin
                ld_result = 1'b1;
                state_nxt = S_WRLED;
            end
            S_WRLED: begin
                poll_clr  = 1'b1;
                state_nxt = S_POLLLED;
            end
            S_POLLLED: begin
                // Once a write is issued, the ack is always awaited,
                // regardless of en.
                if (preaddata[0]) begin
                    round_done = 1'b1;
                    poll_clr   = 1'b1;
                    state_nxt  = en ? S_POLLSW : S_IDLE;
                end else if (poll_limit) begin
                    state_nxt   = S_IDLE;
                    set_timeout = 1'b1;
                end else begin
                    poll_inc  = 1'b1;
                    gap_clr   = 1'b1;
                    state_nxt = (POLL_GAP == 0) ? S_POLLLED : S_GAPLED;
                end
            end
            S_GAPLED: begin
                if (gap_cnt == GC_LAST) begin
                    state_nxt = S_POLLLED;
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counters and captured data
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            lo       <= '0;
            hi       <= '0;
            result   <= '0;
            rounds   <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            en_d     <= 1'b0;
        end else begin
            state <= state_nxt;
            en_d  <= en;
            done  <= round_done;

            if (poll_clr) begin
                poll_cnt <= '0;
            end else if (poll_inc) begin
                poll_cnt <= poll_cnt + PC_W'(1);
            end

            if (gap_clr) begin
                gap_cnt <= '0;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + GC_W'(1);
            end

            if (ld_lo) begin
                lo <= preaddata[7:0];
            end
            if (ld_hi) begin
                hi <= preaddata[7:0];
            end
            if (ld_result) begin
                result <= combine(op, hi, lo);
            end
            if (round_done) begin
                rounds <= rounds + 16'd1;
            end

            // A new error outranks a simultaneous clear, so it is never lost.
            if (set_timeout) begin
                timeout <= 1'b1;
            end else if (en && !en_d) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_poll_master.sv
// ---------------------------------------------------------------------------
// tb_io_poll_master
//
// Directed bench for io_poll_master (POLL_GAP=4, TIMEOUT=8).
// A small peripheral model answers the bus. Switch-ready and LED-ack are
// controlled by the stimulus. Every strobe is logged with its address and
// cycle number.
// ---------------------------------------------------------------------------
module tb_io_poll_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  op;
    logic        pread;
    logic        pwrite;
    logic [1:0]  addr;
    logic [11:0] pwritedata;
    logic [31:0] preaddata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [11:0] result;
    logic [15:0] rounds;

    logic        sw_rdy;
    logic        ack_hold;
    logic        led_pend = 1'b0;
    logic        both_seen = 1'b0;
    logic [15:0] sw;

    int cyc = 0;
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int wr_addr_q[$];
    int wr_data_q[$];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;
    int exp_rounds = 0;
    int exp_rd[7] = '{0, 0, 0, 0, 2, 3, 0};
    int n;

    always #5 clk = ~clk;

    io_poll_master #(
        .POLL_GAP (4),
        .TIMEOUT  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .op         (op),
        .pread      (pread),
        .pwrite     (pwrite),
        .addr       (addr),
        .pwritedata (pwritedata),
        .preaddata  (preaddata),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result     (result),
        .rounds     (rounds)
    );

    // Peripheral model. The junk in the unused bits makes sure the DUT
    // selects only the fields it should.
    always_comb begin
        preaddata = 32'h0;
        if (pread) begin
            case (addr)
                2'b00:   preaddata = {24'hC3C3C3, 6'b101010, sw_rdy, led_pend & ~ack_hold};
                2'b10:   preaddata = {24'hA5A5A5, sw[7:0]};
                2'b11:   preaddata = {24'h5A5A5A, sw[15:8]};
                default: preaddata = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pread && pwrite) both_seen <= 1'b1;
        if (pread) begin
            rd_addr_q.push_back(int'(addr));
            rd_cyc_q.push_back(cyc);
        end
        if (pwrite) begin
            wr_addr_q.push_back(int'(addr));
            wr_data_q.push_back(int'(pwritedata));
        end
        if (pwrite) led_pend <= 1'b1;
        else if (pread && addr == 2'b00 && led_pend && !ack_hold) led_pend <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // One full round with the switch already ready; en drops once the write is seen.
    task automatic run_round(input string tag, input logic [1:0] f_op,
                             input logic [15:0] f_sw, input logic [11:0] exp);
        int k;
        clear_logs();
        op = f_op;
        sw = f_sw;
        sw_rdy = 1'b1;
        en = 1'b1;
        k = 0;
        while (wr_data_q.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        en = 1'b0;
        check({tag, "_wr_seen"}, 32'(wr_data_q.size()), 32'd1);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        exp_rounds++;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_data"}, (wr_data_q.size() > 0) ? wr_data_q[0] : -1, 32'(exp));
        check({tag, "_result"}, 32'(result), 32'(exp));
        check({tag, "_rounds"}, 32'(rounds), 32'(exp_rounds));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        op       = 2'b00;
        sw       = 16'h0000;
        sw_rdy   = 1'b0;
        ack_hold = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_pread",  32'(pread),      32'd0);
        check("rst_pwrite", 32'(pwrite),     32'd0);
        check("rst_done",   32'(done),       32'd0);
        check("rst_to",     32'(timeout),    32'd0);
        check("rst_result", 32'(result),     32'd0);
        check("rst_rounds", 32'(rounds),     32'd0);
        check("rst_wdata",  32'(pwritedata), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_en0", 32'(busy), 32'd0);

        // Three not-ready polls, then 16'h1234 with add
        clear_logs();
        sw = 16'h1234;
        op = 2'b00;
        en = 1'b1;
        n = 0;
        while (rd_addr_q.size() < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        sw_rdy = 1'b1;
        check("t2_three_polls", 32'(rd_addr_q.size()), 32'd3);
        n = 0;
        while (wr_data_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_rounds++;
        check("t2_done", 32'(done), 32'd1);
        check("t2_nreads", 32'(rd_addr_q.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("t2_rd%0d", i), (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, exp_rd[i]);
        if (rd_cyc_q.size() >= 6) begin
            check("t4_gap01", rd_cyc_q[1] - rd_cyc_q[0], 32'd5);
            check("t4_gap12", rd_cyc_q[2] - rd_cyc_q[1], 32'd5);
            check("t4_gap23", rd_cyc_q[3] - rd_cyc_q[2], 32'd5);
            check("t2_lo_next", rd_cyc_q[4] - rd_cyc_q[3], 32'd1);
            check("t2_hi_next", rd_cyc_q[5] - rd_cyc_q[4], 32'd1);
        end
        check("t2_nwrites", 32'(wr_addr_q.size()), 32'd1);
        check("t2_wr_addr", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 32'd1);
        check("t2_wr_data", (wr_data_q.size() > 0) ? wr_data_q[0] : -1, 32'h046);
        check("t2_result", 32'(result), 32'h046);
        check("t2_rounds", 32'(rounds), 32'd1);
        @(negedge clk);
        check("t2_pulse", 32'(done), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // Combine ops, sw = {hi, lo}
        run_round("sub", 2'b01, 16'h1020, 12'hFF0);
        run_round("mul_sat", 2'b10, 16'hFFFF, 12'hFFF);
        run_round("cat", 2'b11, 16'hABCD, 12'hBCD);
        run_round("mul", 2'b10, 16'h1020, 12'h200);
        run_round("add_max", 2'b00, 16'hFFFF, 12'h1FE);
        run_round("sub_pos", 2'b01, 16'h2010, 12'h010);

        // Timeout: switch never ready
        clear_logs();
        sw_rdy = 1'b0;
        en = 1'b1;
        n = 0;
        while (!timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        check("t5_timeout", 32'(timeout), 32'd1);
        check("t5_nreads", 32'(rd_addr_q.size()), 32'd8);
        check("t5_idle", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        check("t5_sticky", 32'(timeout), 32'd1);
        check("t5_no_more_reads", 32'(rd_addr_q.size()), 32'd8);
        en = 1'b1;
        @(negedge clk);
        check("t5_cleared", 32'(timeout), 32'd0);
        check("t6_in_pollsw", 32'(pread), 32'd1);

        // en dropped in S_POLLSW, with the switch ready in that very read
        clear_logs();
        sw_rdy = 1'b1;
        en = 1'b0;
        repeat (10) @(negedge clk);
        check("t6a_idle", 32'(busy), 32'd0);
        check("t6a_no_write", 32'(wr_addr_q.size()), 32'd0);
        check("t6a_one_read", 32'(rd_addr_q.size()), 32'd1);

        // en dropped in S_WRLED, with the ack held back for a while
        clear_logs();
        sw = 16'h0102;
        op = 2'b00;
        en = 1'b1;
        n = 0;
        while (!pwrite && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6b_pwrite", 32'(pwrite), 32'd1);
        check("t6b_addr", 32'(addr), 32'd1);
        check("t6b_wdata", 32'(pwritedata), 32'h003);
        en = 1'b0;
        ack_hold = 1'b1;
        repeat (12) @(negedge clk);
        check("t6b_still_busy", 32'(busy), 32'd1);
        check("t6b_no_done", 32'(done), 32'd0);
        ack_hold = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        exp_rounds++;
        check("t6b_done", 32'(done), 32'd1);
        check("t6b_rounds", 32'(rounds), 32'(exp_rounds));
        check("t6b_nwrites", 32'(wr_addr_q.size()), 32'd1);
        @(negedge clk);
        check("t6b_idle", 32'(busy), 32'd0);

        // Async reset in the middle of S_RDHI
        clear_logs();
        sw = 16'h5566;
        sw_rdy = 1'b1;
        en = 1'b1;
        n = 0;
        while (!(pread && addr == 2'b11) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1_in_rdhi", 32'(addr), 32'd3);
        reset = 1'b0;
        en = 1'b0;
        #1;
        check("t1_pread", 32'(pread), 32'd0);
        check("t1_pwrite", 32'(pwrite), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_rounds", 32'(rounds), 32'd0);
        check("t1_result", 32'(result), 32'd0);
        repeat (2) @(negedge clk);
        check("t1_no_hi_strobe", 32'(rd_addr_q.size()), 32'd2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("t1_idle_after", 32'(busy), 32'd0);

        check("never_both_strobes", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
